// File: rtl/bus_target_pkg.sv
// Shared types and default parameter values for the bus target memory.
package bus_target_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_MEM_AW    = 4;
  localparam int unsigned DEF_BASE_ADDR = 0;
  localparam int unsigned DEF_READ_LAT  = 1;
  localparam int unsigned DEF_WDATA_TMO = 16;
  // Wide enough for both READ_LAT (<=15) and WDATA_TMO (<=255)
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_WDATA = 2'd1,
    READ_WAIT  = 2'd2,
    RESP       = 2'd3
  } state_t;

endpackage

// File: rtl/bus_target_mem_if.sv
// Request/response bus between a master and the bus target memory.
interface bus_target_mem_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] s_address_in;
  logic              s_address_in_valid;
  logic              s_rw;
  logic [DATA_W-1:0] s_data_in;
  logic              s_data_in_valid;
  logic [DATA_W-1:0] s_data_out;
  logic              s_data_out_valid;
  logic              s_ack;
  logic              s_err;
  logic              s_ready;
  logic [DATA_W-1:0] s_last_write;

  modport master (
    output s_address_in, s_address_in_valid, s_rw, s_data_in, s_data_in_valid,
    input  s_data_out, s_data_out_valid, s_ack, s_err, s_ready, s_last_write
  );

  modport slave (
    input  s_address_in, s_address_in_valid, s_rw, s_data_in, s_data_in_valid,
    output s_data_out, s_data_out_valid, s_ack, s_err, s_ready, s_last_write
  );
endinterface

// File: rtl/bus_target_storage.sv
// Word array with synchronous write and combinational read; intentionally not reset.
module bus_target_storage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_c
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];
endmodule

// File: rtl/bus_target_mem.sv
// Memory-mapped bus target: decodes a window, serves reads with fixed latency,
// waits (bounded) for late write data.
module bus_target_mem
  import bus_target_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MEM_AW    = DEF_MEM_AW,
  parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
  parameter int unsigned READ_LAT  = DEF_READ_LAT,
  parameter int unsigned WDATA_TMO = DEF_WDATA_TMO
) (
  input logic              clk,
  input logic              rst_n,
  bus_target_mem_if.slave  bus
);
  localparam int unsigned TAG_W = ADDR_W - MEM_AW;
  localparam logic [TAG_W-1:0] BASE_TAG = TAG_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(WDATA_TMO - 1);

  state_t              state_q, state_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                dvalid_q, dvalid_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   lw_q, lw_d;

  logic                hit_c;
  logic [MEM_AW-1:0]   req_idx_c;
  logic                we_c;
  logic [MEM_AW-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   rdata_c;

  assign hit_c      = (bus.s_address_in[ADDR_W-1:MEM_AW] == BASE_TAG);
  assign req_idx_c  = bus.s_address_in[MEM_AW-1:0];
  // In IDLE the live request index addresses storage; otherwise the latched one
  assign mem_addr_c = (state_q == IDLE) ? req_idx_c : idx_q;

  bus_target_storage #(.DATA_W(DATA_W), .AW(MEM_AW)) u_storage (
    .clk     (clk),
    .we      (we_c),
    .waddr   (mem_addr_c),
    .wdata   (bus.s_data_in),
    .raddr   (mem_addr_c),
    .rdata_c (rdata_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      dout_q   <= '0;
      lw_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dvalid_q <= dvalid_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
      lw_q     <= lw_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dvalid_d = 1'b0;
    dout_d   = dout_q;
    lw_d     = lw_q;
    we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.s_address_in_valid) begin
          if (!hit_c) begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end else if (bus.s_rw) begin
            if (bus.s_data_in_valid) begin
              we_c  = 1'b1;
              lw_d  = bus.s_data_in;
              ack_d = 1'b1;
            end else begin
              idx_d   = req_idx_c;
              cnt_d   = '0;
              state_d = WAIT_WDATA;
            end
          end else if (READ_LAT == 1) begin
            dout_d   = rdata_c;
            dvalid_d = 1'b1;
            ack_d    = 1'b1;
          end else begin
            idx_d   = req_idx_c;
            cnt_d   = '0;
            state_d = READ_WAIT;
          end
        end
      end
      WAIT_WDATA: begin
        if (bus.s_data_in_valid) begin
          we_c    = 1'b1;
          lw_d    = bus.s_data_in;
          ack_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ_WAIT: begin
        // Response registers load on the last wait cycle so they show in RESP
        if (cnt_q == RD_LAST) begin
          dout_d   = rdata_c;
          dvalid_d = 1'b1;
          ack_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  assign bus.s_ack            = ack_q;
  assign bus.s_err            = err_q;
  assign bus.s_data_out_valid = dvalid_q;
  assign bus.s_data_out       = dout_q;
  assign bus.s_ready          = ready_q;
  assign bus.s_last_write     = lw_q;
endmodule

// File: tb/tb_bus_target_mem.sv
// Self-checking bench for bus_target_mem: default, offset-window and long-latency builds.
module tb_bus_target_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_target_mem_if #(.DATA_W(8), .ADDR_W(16)) i0 ();
  bus_target_mem_if #(.DATA_W(8), .ADDR_W(16)) i1 ();
  bus_target_mem_if #(.DATA_W(8), .ADDR_W(16)) i2 ();

  bus_target_mem u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  bus_target_mem #(.BASE_ADDR(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  bus_target_mem #(.READ_LAT(3))   u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));

  int n_chk = 0;
  int n_err = 0;

  // Reference model for u0: contents of the 16-word window plus visible registers
  logic [7:0] mem_m [16];
  logic [7:0] last_wr = 8'h00;
  logic [7:0] last_rd = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // delay: 0 = data with address, >0 = data that many cycles later, <0 = never
  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int delay);
    logic hit;
    int   idle;
    hit = (addr[15:4] == 12'h000);
    i0.s_address_in       = addr;
    i0.s_address_in_valid = 1'b1;
    i0.s_rw               = 1'b1;
    i0.s_data_in          = data;
    i0.s_data_in_valid    = (delay == 0);
    tick();
    i0.s_address_in_valid = 1'b0;
    i0.s_data_in_valid    = 1'b0;
    if (!hit || delay == 0) begin
      if (hit) begin
        mem_m[addr[3:0]] = data;
        last_wr = data;
      end
      chk("wr_ack",   32'(i0.s_ack),   32'd1);
      chk("wr_err",   32'(i0.s_err),   32'(!hit));
      chk("wr_ready", 32'(i0.s_ready), 32'd1);
      chk("wr_last",  32'(i0.s_last_write), 32'(last_wr));
    end else begin
      chk("wr_wait_ready", 32'(i0.s_ready), 32'd0);
      chk("wr_wait_ack",   32'(i0.s_ack),   32'd0);
      // A competing read while busy must be ignored, not queued
      i0.s_address_in_valid = 1'b1;
      i0.s_rw               = 1'b0;
      idle = (delay < 0) ? 15 : delay - 1;
      for (int i = 0; i < idle; i++) begin
        tick();
        chk("wr_wait_ack_lo", 32'(i0.s_ack),   32'd0);
        chk("wr_wait_rdy_lo", 32'(i0.s_ready), 32'd0);
      end
      if (delay > 0) i0.s_data_in_valid = 1'b1;
      tick();
      i0.s_data_in_valid    = 1'b0;
      i0.s_address_in_valid = 1'b0;
      if (delay > 0) begin
        mem_m[addr[3:0]] = data;
        last_wr = data;
      end
      chk("wr_late_ack",   32'(i0.s_ack),   32'd1);
      chk("wr_late_err",   32'(i0.s_err),   32'(delay < 0));
      chk("wr_late_ready", 32'(i0.s_ready), 32'd1);
      chk("wr_late_last",  32'(i0.s_last_write), 32'(last_wr));
      tick();
      chk("wr_single_ack", 32'(i0.s_ack), 32'd0);
    end
  endtask

  task automatic do_read(input logic [15:0] addr);
    logic hit;
    hit = (addr[15:4] == 12'h000);
    i0.s_address_in       = addr;
    i0.s_address_in_valid = 1'b1;
    i0.s_rw               = 1'b0;
    tick();
    i0.s_address_in_valid = 1'b0;
    if (hit) last_rd = mem_m[addr[3:0]];
    chk("rd_ack",    32'(i0.s_ack),            32'd1);
    chk("rd_err",    32'(i0.s_err),            32'(!hit));
    chk("rd_valid",  32'(i0.s_data_out_valid), 32'(hit));
    chk("rd_data",   32'(i0.s_data_out),       32'(last_rd));
    chk("rd_ready",  32'(i0.s_ready),          32'd1);
  endtask

  initial begin
    logic [15:0] a;
    int r;
    i0.s_address_in = '0; i0.s_address_in_valid = 1'b0; i0.s_rw = 1'b0;
    i0.s_data_in = '0;    i0.s_data_in_valid = 1'b0;
    i1.s_address_in = '0; i1.s_address_in_valid = 1'b0; i1.s_rw = 1'b0;
    i1.s_data_in = '0;    i1.s_data_in_valid = 1'b0;
    i2.s_address_in = '0; i2.s_address_in_valid = 1'b0; i2.s_rw = 1'b0;
    i2.s_data_in = '0;    i2.s_data_in_valid = 1'b0;

    repeat (3) tick();
    chk("rst_ack",    32'(i0.s_ack),            32'd0);
    chk("rst_err",    32'(i0.s_err),            32'd0);
    chk("rst_valid",  32'(i0.s_data_out_valid), 32'd0);
    chk("rst_dout",   32'(i0.s_data_out),       32'd0);
    chk("rst_lastwr", 32'(i0.s_last_write),     32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready",  32'(i0.s_ready),          32'd1);

    // Fill every word so later reads are defined
    for (int i = 0; i < 16; i++) do_write(16'(i), 8'($urandom), 0);

    do_write(16'h0003, 8'hA5, 0);
    do_read(16'h0003);
    chk("a5_lastwr", 32'(i0.s_last_write), 32'h0000_00A5);

    do_write(16'h0007, 8'h3C, 2);
    do_read(16'h0007);

    do_write(16'h0003, 8'h99, -1);
    do_read(16'h0003);

    do_write(16'h1234, 8'h42, 0);
    do_read(16'h1234);

    for (int t = 0; t < 60; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16, 65535))
                                      : 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 9);
        do_write(a, 8'($urandom), (r <= 4 || r == 9) ? 0 : (r == 8) ? -1 : r - 4);
      end else begin
        do_read(a);
      end
    end

    // Reset while waiting for write data abandons the write
    do_write(16'h0009, 8'h11, 0);
    i0.s_address_in = 16'h0009; i0.s_address_in_valid = 1'b1; i0.s_rw = 1'b1;
    tick();
    i0.s_address_in_valid = 1'b0;
    chk("mid_rst_busy", 32'(i0.s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",   32'(i0.s_ack),            32'd0);
    chk("mid_rst_err",   32'(i0.s_err),            32'd0);
    chk("mid_rst_valid", 32'(i0.s_data_out_valid), 32'd0);
    chk("mid_rst_dout",  32'(i0.s_data_out),       32'd0);
    chk("mid_rst_lw",    32'(i0.s_last_write),     32'd0);
    #3 rst_n = 1'b1;
    last_wr = 8'h00;
    last_rd = 8'h00;
    i0.s_data_in = 8'hEE; i0.s_data_in_valid = 1'b1;
    tick();
    i0.s_data_in_valid = 1'b0;
    chk("post_rst_ack",   32'(i0.s_ack),        32'd0);
    chk("post_rst_ready", 32'(i0.s_ready),      32'd1);
    chk("post_rst_lw",    32'(i0.s_last_write), 32'd0);
    do_read(16'h0009);

    // Window at upper field 0x010: 0x0105 hits index 5, 0x0025 and 0x0005 miss
    i1.s_address_in = 16'h0105; i1.s_rw = 1'b1; i1.s_data_in = 8'h5A;
    i1.s_address_in_valid = 1'b1; i1.s_data_in_valid = 1'b1;
    tick();
    chk("b_wr_ack", 32'(i1.s_ack), 32'd1);
    chk("b_wr_err", 32'(i1.s_err), 32'd0);
    i1.s_address_in = 16'h0025; i1.s_rw = 1'b0; i1.s_data_in_valid = 1'b0;
    tick();
    chk("b_miss_ack",   32'(i1.s_ack),            32'd1);
    chk("b_miss_err",   32'(i1.s_err),            32'd1);
    chk("b_miss_valid", 32'(i1.s_data_out_valid), 32'd0);
    i1.s_address_in = 16'h0005; i1.s_rw = 1'b1; i1.s_data_in = 8'hFF; i1.s_data_in_valid = 1'b1;
    tick();
    chk("b_wmiss_err", 32'(i1.s_err), 32'd1);
    i1.s_address_in = 16'h0105; i1.s_rw = 1'b0; i1.s_data_in_valid = 1'b0;
    tick();
    i1.s_address_in_valid = 1'b0;
    chk("b_hit_err",   32'(i1.s_err),            32'd0);
    chk("b_hit_valid", 32'(i1.s_data_out_valid), 32'd1);
    chk("b_hit_data",  32'(i1.s_data_out),       32'h0000_005A);

    // Three-cycle read latency; a request during the wait is dropped
    i2.s_address_in = 16'h0002; i2.s_rw = 1'b1; i2.s_data_in = 8'h77;
    i2.s_address_in_valid = 1'b1; i2.s_data_in_valid = 1'b1;
    tick();
    i2.s_data_in_valid = 1'b0;
    chk("l_wr_ack", 32'(i2.s_ack), 32'd1);
    i2.s_rw = 1'b0;
    tick();
    chk("l_n1_ack",   32'(i2.s_ack),   32'd0);
    chk("l_n1_ready", 32'(i2.s_ready), 32'd0);
    tick();
    i2.s_address_in_valid = 1'b0;
    chk("l_n2_ack",   32'(i2.s_ack),            32'd0);
    chk("l_n2_valid", 32'(i2.s_data_out_valid), 32'd0);
    tick();
    chk("l_n3_ack",   32'(i2.s_ack),            32'd1);
    chk("l_n3_valid", 32'(i2.s_data_out_valid), 32'd1);
    chk("l_n3_data",  32'(i2.s_data_out),       32'h0000_0077);
    chk("l_n3_ready", 32'(i2.s_ready),          32'd0);
    tick();
    chk("l_n4_ready", 32'(i2.s_ready), 32'd1);
    chk("l_n4_ack",   32'(i2.s_ack),   32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l_no_extra_ack", 32'(i2.s_ack), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_target_mem.md
BUS_TARGET_MEM -- requirements
Module: bus_target_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width.
REQ-002 SHALL have parameter ADDR_W, default 16, bus address width.
REQ-003 SHALL have parameter MEM_AW, default 4, local index width; depth = 2^MEM_AW; 1 <= MEM_AW < ADDR_W.
REQ-004 SHALL have parameter BASE_ADDR, default 0, decoded against address bits [ADDR_W-1:MEM_AW].
REQ-005 SHALL have parameter READ_LAT, default 1, read latency in cycles, range 1..15.
REQ-006 SHALL have parameter WDATA_TMO, default 16, max wait cycles for write data, range 1..255.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 s_address_in  in  ADDR_W  request address.
REQ-010 s_address_in_valid  in  1  request strobe.
REQ-011 s_rw  in  1  1 = write, 0 = read; sampled with address.
REQ-012 s_data_in  in  DATA_W  write data.
REQ-013 s_data_in_valid  in  1  write data strobe.
REQ-014 s_data_out  out  DATA_W  read data; holds last read value.
REQ-015 s_data_out_valid  out  1  one-cycle read data pulse.
REQ-016 s_ack  out  1  one-cycle completion pulse; every accepted request gets exactly one.
REQ-017 s_err  out  1  one-cycle error flag; asserted only together with s_ack.
REQ-018 s_ready  out  1  1 only in IDLE; requests are accepted only while high.
REQ-019 s_last_write  out  DATA_W  last data value written to storage.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT_WDATA, READ_WAIT, RESP.
REQ-021 IDLE with s_address_in_valid SHALL accept request; hit = address[ADDR_W-1:MEM_AW] equals BASE_ADDR upper bits; index = address[MEM_AW-1:0].
REQ-022 Miss (any direction) SHALL not touch storage; s_ack and s_err pulse at N+1; write data presented at N is discarded.
REQ-023 Write hit with s_data_in_valid in accept cycle N SHALL write storage and s_last_write at edge N; s_ack pulses at N+1; stay IDLE.
REQ-024 Write hit without data SHALL latch index, go WAIT_WDATA, zero timeout counter.
REQ-025 WAIT_WDATA with s_data_in_valid at cycle M SHALL write latched index; s_ack pulses at M+1; return IDLE.
REQ-026 WAIT_WDATA after WDATA_TMO cycles without data SHALL abort: no write; s_ack+s_err pulse; return IDLE.
REQ-027 s_address_in_valid while s_ready=0 SHALL be ignored; never queued.
REQ-028 Read hit at N SHALL present storage[index] on s_data_out with s_data_out_valid and s_ack high at exactly N+READ_LAT; READ_LAT=1 needs no READ_WAIT; READ_LAT>1 uses READ_WAIT counting READ_LAT-1 cycles, then RESP.
REQ-029 Read data SHALL be sampled from storage at the response cycle; a write cannot occur during a read (s_ready=0).
REQ-030 s_ready SHALL drop the cycle after accepting any multi-cycle operation and rise on return to IDLE; back-to-back single-cycle requests accepted every cycle.
REQ-031 Storage SHALL not be reset; contents are undefined until written.

Reset
REQ-032 On rst_n low: state IDLE, s_data_out 0, s_data_out_valid 0, s_ack 0, s_err 0, s_last_write 0, counters 0; s_ready 1 after release.
REQ-033 Reset mid-operation SHALL abandon pending write/read with no ack and no storage write.

Structure
REQ-034 Package bus_target_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-035 Storage SHALL be sub-module bus_target_storage: 2^MEM_AW x DATA_W, synchronous write, combinational read.
REQ-036 Implementation SHALL be synthesizable, single clock domain, no latches.

Verification
REQ-037 Defaults; write addr 0x0003 data 0xA5 same cycle, then read 0x0003 -> ack next cycle; read returns 0xA5, s_last_write 0xA5.
REQ-038 Write 0x0007 addr only, data 0x3C two cycles later -> s_ready low meanwhile, ack one cycle after data, read 0x0007 returns 0x3C.
REQ-039 Write addr only, no data for 16 cycles -> s_ack+s_err pulse, storage unchanged, s_ready high next cycle.
REQ-040 BASE_ADDR=0x10, MEM_AW=4; read 0x0025 -> s_ack+s_err at N+1, s_data_out_valid 0; read 0x0105 hits index 5.
REQ-041 READ_LAT=3; read at N -> s_data_out_valid and s_ack exactly at N+3; request at N+1 ignored.
REQ-042 Assert rst_n during WAIT_WDATA -> no ack, outputs 0, later data pulse causes no write.
